// File: rtl/bus_rr_scheduler_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : bus_rr_scheduler_if                                              |
// | Purpose  : Bundles the source-FIFO, destination-FIFO and status signals of   |
// |            the round-robin packet bus scheduler.                             |
// | Ports    : pndng    - per-source "FIFO non-empty"                           |
// |            D_pop    - head words of all source FIFOs, slice i = device i     |
// |            pop      - one-hot pop strobe to the granted source FIFO         |
// |            dst_full - per-destination "FIFO cannot accept a push"           |
// |            push     - push strobe(s) to destination FIFOs                   |
// |            D_push   - packet presented to every destination FIFO            |
// |            busy     - scheduler is not idle                                  |
// |            grant_id - current or last granted source index                  |
// |            pkt_cnt  - delivered packets (wrapping)                          |
// |            drop_cnt - dropped packets (saturating)                          |
// | Modports : master - scheduler side; slave - FIFO/environment side           |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
interface bus_rr_scheduler_if #(
  parameter int DRVRS   = 16,
  parameter int PCKG_SZ = 16
);
  logic [DRVRS-1:0]         pndng;
  logic [DRVRS*PCKG_SZ-1:0] D_pop;
  logic [DRVRS-1:0]         pop;
  logic [DRVRS-1:0]         dst_full;
  logic [DRVRS-1:0]         push;
  logic [PCKG_SZ-1:0]       D_push;
  logic                     busy;
  logic [7:0]               grant_id;
  logic [15:0]              pkt_cnt;
  logic [7:0]               drop_cnt;

  modport master (
    input  pndng, D_pop, dst_full,
    output pop, push, D_push, busy, grant_id, pkt_cnt, drop_cnt
  );

  modport slave (
    output pndng, D_pop, dst_full,
    input  pop, push, D_push, busy, grant_id, pkt_cnt, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/bus_rr_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : bus_rr_scheduler                                                 |
// | Purpose  : Round-robin scheduler for a shared packet bus. Grants one        |
// |            pending source FIFO, pops one packet, decodes the destination    |
// |            ID from the top 8 bits and pushes it to one destination or       |
// |            broadcasts it to every device except the source.                 |
// | Ports    : clk   - bus clock, rising edge                                   |
// |            reset - asynchronous, active-high                                |
// |            bus   - bus_rr_scheduler_if.master (pndng/D_pop/pop,             |
// |                    dst_full/push/D_push, busy/grant_id/pkt_cnt/drop_cnt)    |
// | Options  : ARB_PUSH_TIMEOUT_EN - when defined, a packet that waits TIMEOUT  |
// |            cycles in PUSH without being accepted is dropped.               |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module bus_rr_scheduler #(
  parameter int         DRVRS     = 16,
  parameter int         PCKG_SZ   = 16,
  parameter logic [7:0] BROADCAST = 8'hFF,
  parameter int         TIMEOUT   = 64
) (
  input  wire logic          clk,
  input  wire logic          reset,
  bus_rr_scheduler_if.master bus
);

  localparam int c_IW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_DECODE = 3'd2,
    S_PUSH   = 3'd3,
    S_DROP   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [c_IW-1:0]    r_ptr;
  logic [c_IW-1:0]    r_grant;
  logic [PCKG_SZ-1:0] r_pkt;
  logic [DRVRS-1:0]   r_mask;
  logic [15:0]        r_pkt_cnt;
  logic [7:0]         r_drop_cnt;

  logic [c_IW-1:0]    w_pick;
  logic [PCKG_SZ-1:0] w_slot [DRVRS];
  logic [DRVRS-1:0]   w_grant_oh;
  logic [DRVRS-1:0]   w_mask_bc;
  logic [DRVRS-1:0]   w_mask_uc;
  logic [7:0]         w_id;
  logic               w_bcast;
  logic               w_route_ok;
  logic               w_fire;
  logic               w_expire;
  logic [DRVRS-1:0]   w_pop;
  logic [DRVRS-1:0]   w_push;

  // Per-device views of the flattened head-word bus and per-device masks.
  for (genvar gi = 0; gi < DRVRS; gi++) begin : g_dev
    assign w_slot[gi]     = bus.D_pop[gi*PCKG_SZ +: PCKG_SZ];
    assign w_grant_oh[gi] = (r_grant == c_IW'(gi));
    assign w_mask_bc[gi]  = (r_grant != c_IW'(gi));
    assign w_mask_uc[gi]  = (int'(w_id) == gi);
  end

  // Round-robin pick: the pending source with the smallest forward distance
  // from ptr+1 (wrapping) wins, so the last grant gets the lowest priority.
  always_comb begin
    int v_best;
    int v_dist;
    w_pick = '0;
    v_best = DRVRS;
    v_dist = 0;
    for (int i = 0; i < DRVRS; i++) begin
      if (i > int'(r_ptr)) begin
        v_dist = i - int'(r_ptr) - 1;
      end else begin
        v_dist = i + DRVRS - int'(r_ptr) - 1;
      end
      if (bus.pndng[i] && (v_dist < v_best)) begin
        v_best = v_dist;
        w_pick = c_IW'(i);
      end
    end
  end

  // Destination decode on the captured packet. Broadcast is checked first so
  // it wins even if its code happens to fall inside the device range.
  assign w_id       = r_pkt[PCKG_SZ-1 -: 8];
  assign w_bcast    = (w_id == BROADCAST);
  assign w_route_ok = w_bcast ||
                      ((int'(w_id) < DRVRS) && (int'(w_id) != int'(r_grant)));

  // All targeted FIFOs must have room; a broadcast is never split.
  assign w_fire = ((r_mask & bus.dst_full) == '0);

`ifdef ARB_PUSH_TIMEOUT_EN
  localparam int c_TW = $clog2(TIMEOUT + 1);

  logic [c_TW-1:0] r_wait;

  // Counter sits at zero outside PUSH, so it is clear on every PUSH entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait <= '0;
    end else if (r_state != S_PUSH) begin
      r_wait <= '0;
    end else if (!w_fire) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  // This no-push cycle is the one that takes the count to TIMEOUT.
  assign w_expire = (r_wait == c_TW'(TIMEOUT - 1));
`else
  logic w_unused_timeout;

  assign w_expire         = 1'b0;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and strobes. pop/push decode from the state register only, so
  // they fall together with an asynchronous reset.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = '0;
    w_push      = '0;
    case (r_state)
      S_IDLE: begin
        if (|bus.pndng) begin
          w_state_nxt = S_POP;
        end
      end
      S_POP: begin
        w_pop       = w_grant_oh;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_state_nxt = w_route_ok ? S_PUSH : S_DROP;
      end
      S_PUSH: begin
        // A push on the expiry cycle still wins.
        if (w_fire) begin
          w_push      = r_mask;
          w_state_nxt = S_IDLE;
        end else if (w_expire) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: grant/pointer, packet capture, routing mask and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr      <= c_IW'(DRVRS - 1);
      r_grant    <= '0;
      r_pkt      <= '0;
      r_mask     <= '0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.pndng) begin
            r_grant <= w_pick;
            r_ptr   <= w_pick;
          end
        end
        S_POP: begin
          // Captured unconditionally; an empty FIFO here is the FIFO's problem.
          r_pkt <= w_slot[r_grant];
        end
        S_DECODE: begin
          r_mask <= w_bcast ? w_mask_bc : w_mask_uc;
        end
        S_PUSH: begin
          if (w_fire) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
          end
        end
        S_DROP: begin
          if (r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.pop      = w_pop;
  assign bus.push     = w_push;
  assign bus.D_push   = r_pkt;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.grant_id = 8'(r_grant);
  assign bus.pkt_cnt  = r_pkt_cnt;
  assign bus.drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
